// File: rtl/sll_pkg.sv
// sll_pkg: shared definitions for the multicycle logical left shifter.
// Holds the controller state encoding, default geometry and the fixed
// start-to-result latency.
package sll_pkg;

    // Default operand width and shift-amount width (SHAMT_W = clog2(WIDTH)).
    localparam int SLL_WIDTH   = 32;
    localparam int SLL_SHAMT_W = 5;

    // Cycles from the accepted start to the data_resultRDY pulse.
    localparam int SLL_LATENCY = 6;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sll_state_e;

    // Width of a counter that walks the stage indices 0 .. stages-1.
    function automatic int sll_cnt_width(input int stages);
        return (stages > 1) ? $clog2(stages) : 1;
    endfunction

endpackage

// File: rtl/sll_multicycle_if.sv
// sll_multicycle_if: start/ready handshake and data bus of the shifter.
// The master side issues operations; the slave side is the shifter.
// Optional macro SLL_OVERFLOW_EN adds the data_overflow signal.
interface sll_multicycle_if
    import sll_pkg::*;
#(
    parameter int WIDTH   = SLL_WIDTH,
    parameter int SHAMT_W = SLL_SHAMT_W
) ();

    logic               ctrl_start;
    logic [WIDTH-1:0]   data_operandA;
    logic [SHAMT_W-1:0] ctrl_shiftamt;
    logic [WIDTH-1:0]   data_result;
    logic               data_resultRDY;
    logic               data_busy;
`ifdef SLL_OVERFLOW_EN
    logic               data_overflow;
`endif

`ifdef SLL_OVERFLOW_EN
    modport master (
        output ctrl_start, data_operandA, ctrl_shiftamt,
        input  data_result, data_resultRDY, data_busy, data_overflow
    );

    modport slave (
        input  ctrl_start, data_operandA, ctrl_shiftamt,
        output data_result, data_resultRDY, data_busy, data_overflow
    );
`else
    modport master (
        output ctrl_start, data_operandA, ctrl_shiftamt,
        input  data_result, data_resultRDY, data_busy
    );

    modport slave (
        input  ctrl_start, data_operandA, ctrl_shiftamt,
        output data_result, data_resultRDY, data_busy
    );
`endif

endinterface

// File: rtl/sll_stage.sv
// sll_stage: one conditional power-of-two left-shift stage.
// Output is value_in << 2^stage_idx when stage_en is set, else value_in.
// Zero-filled from the LSB; bits leaving the MSB are discarded.
module sll_stage
    import sll_pkg::*;
#(
    parameter int WIDTH = SLL_WIDTH,
    parameter int IDX_W = 3
) (
    input  logic [WIDTH-1:0] value_in,
    input  logic [IDX_W-1:0] stage_idx,
    input  logic             stage_en,
    output logic [WIDTH-1:0] value_out
);

    // Apply a shift of 2^stage_idx positions when enabled.
    always_comb begin
        value_out = value_in;
        if (stage_en) begin
            value_out = value_in << (1 << stage_idx);
        end
    end

endmodule

// File: rtl/sll_multicycle.sv
// sll_multicycle: multicycle logical left shifter.
// One conditional power-of-two stage (1, 2, 4, 8, 16) is applied per clock
// through a single shared sll_stage, giving a fixed 6-cycle latency from an
// accepted start to the one-cycle data_resultRDY pulse.
// Optional macro SLL_OVERFLOW_EN adds the signed-overflow flag data_overflow.
module sll_multicycle
    import sll_pkg::*;
#(
    parameter int WIDTH   = SLL_WIDTH,
    parameter int SHAMT_W = SLL_SHAMT_W
) (
    input logic             clock,
    input logic             reset,
    sll_multicycle_if.slave bus
);

    localparam int               CNT_W      = sll_cnt_width(SHAMT_W);
    localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(SHAMT_W - 1);

    sll_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SHAMT_W-1:0] amt_q, amt_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               rdy_q, rdy_d;
    logic               busy_q, busy_d;

    logic               accept;
    logic               complete;
    logic               stage_en;
    logic [WIDTH-1:0]   stage_out;

    // Select the amount bit that gates the stage of the current cycle.
    always_comb begin
        stage_en = amt_q[cnt_q];
    end

    sll_stage #(
        .WIDTH (WIDTH),
        .IDX_W (CNT_W)
    ) u_stage (
        .value_in  (work_q),
        .stage_idx (cnt_q),
        .stage_en  (stage_en),
        .value_out (stage_out)
    );

    // Next-state, datapath and registered-output decode for the controller.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        amt_d    = amt_q;
        work_d   = work_q;
        result_d = result_q;
        rdy_d    = 1'b0;
        busy_d   = 1'b0;
        accept   = 1'b0;
        complete = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.ctrl_start) begin
                    accept  = 1'b1;
                    work_d  = bus.data_operandA;
                    amt_d   = bus.ctrl_shiftamt;
                    cnt_d   = '0;
                    state_d = SHIFT;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end

            SHIFT: begin
                work_d = stage_out;
                if (cnt_q == LAST_STAGE) begin
                    complete = 1'b1;
                    result_d = stage_out;
                    rdy_d    = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    busy_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller and datapath registers; reset overrides any operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            amt_q    <= '0;
            work_q   <= '0;
            result_q <= '0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            amt_q    <= amt_d;
            work_q   <= work_d;
            result_q <= result_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.data_busy      = busy_q;

`ifdef SLL_OVERFLOW_EN
    logic             ovf_pend_q, ovf_pend_d;
    logic             ovf_q, ovf_d;
    logic             ovf_in;
    logic [WIDTH-1:0] top_mask;
    logic [WIDTH-1:0] top_bits;

    // The operand's top (amt+1) bits must all match for the shifted value to
    // still equal operand*2^amt as a signed number; evaluated at capture and
    // held until the result is committed so both update together.
    always_comb begin
        top_mask = ~({WIDTH{1'b1}} >> (32'(bus.ctrl_shiftamt) + 32'd1));
        top_bits = bus.data_operandA & top_mask;
        ovf_in   = (top_bits != '0) && (top_bits != top_mask);
    end

    // Capture the pending flag on accept; publish it alongside data_result.
    always_comb begin
        ovf_pend_d = ovf_pend_q;
        ovf_d      = ovf_q;
        if (accept) begin
            ovf_pend_d = ovf_in;
        end
        if (complete) begin
            ovf_d = ovf_pend_q;
        end
    end

    // Overflow flag registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            ovf_pend_q <= ovf_pend_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.data_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_sll_multicycle.sv
// tb_sll_multicycle: self-checking bench for sll_multicycle.
// Table-driven directed vectors, randomized operations against an arithmetic
// reference model, and hand-written multi-cycle sequences (dropped start,
// reset mid-shift, back-to-back starts).
module tb_sll_multicycle;

    localparam int W  = 32;
    localparam int SW = 5;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    sll_multicycle_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();

    sll_multicycle #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    logic [W-1:0] last_res = '0;

    typedef struct {
        logic [W-1:0]  a;
        logic [SW-1:0] amt;
        logic [W-1:0]  exp_res;
        logic          exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: result is operand*2^amt modulo 2^W.
    function automatic logic [W-1:0] model_res(input logic [W-1:0] a, input int unsigned amt);
        logic [63:0] p;
        p = {32'd0, a} * (64'd1 << amt);
        return p[W-1:0];
    endfunction

    // Reference: signed overflow when the signed result differs from a*2^amt.
    function automatic logic model_ovf(input logic [W-1:0] a, input int unsigned amt);
        longint sa;
        longint prod;
        longint sr;
        logic [W-1:0] r;
        sa   = longint'($signed(a));
        prod = sa * (longint'(1) << amt);
        r    = model_res(a, amt);
        sr   = longint'($signed(r));
        return prod != sr;
    endfunction

    // Issue one operation and check latency, busy window, result and hold.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [SW-1:0] amt,
                          input logic [W-1:0] exp_res, input logic exp_ovf);
        int lat;
        int busy_cnt;
        lat      = 0;
        busy_cnt = 0;
        bus.ctrl_start    = 1'b1;
        bus.data_operandA = a;
        bus.ctrl_shiftamt = amt;
        tick();
        bus.ctrl_start    = 1'b0;
        bus.data_operandA = $urandom;
        bus.ctrl_shiftamt = SW'($urandom);
        for (int c = 1; c <= 12; c++) begin
            if (c == 3) check({tag, " result held mid-shift"}, 64'(bus.data_result), 64'(last_res));
            if (bus.data_busy) busy_cnt++;
            if (bus.data_resultRDY) begin
                lat = c;
                break;
            end
            tick();
        end
        check({tag, " rdy latency"}, 64'(lat), 64'd6);
        check({tag, " busy cycles"}, 64'(busy_cnt), 64'd5);
        check({tag, " result"}, 64'(bus.data_result), 64'(exp_res));
`ifdef SLL_OVERFLOW_EN
        check({tag, " overflow"}, 64'(bus.data_overflow), 64'(exp_ovf));
`endif
        last_res = exp_res;
        tick();
        check({tag, " rdy single pulse"}, 64'(bus.data_resultRDY), 64'd0);
        check({tag, " idle after done"}, 64'(bus.data_busy), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        logic [W-1:0] ra;
        logic [SW-1:0] ramt;
        int pulses;
        int first;
        int at[2];
        logic [W-1:0] rs[2];

        vecs[0] = '{32'h12345678, 5'd0,  32'h12345678, 1'b0};
        vecs[1] = '{32'h00000001, 5'd31, 32'h80000000, 1'b1};
        vecs[2] = '{32'hFFFFFFFF, 5'd4,  32'hFFFFFFF0, 1'b0};
        vecs[3] = '{32'h40000000, 5'd1,  32'h80000000, 1'b1};
        vecs[4] = '{32'hFFFFFFFF, 5'd31, 32'h80000000, 1'b0};
        vecs[5] = '{32'h80000000, 5'd1,  32'h00000000, 1'b1};
        vecs[6] = '{32'hDEADBEEF, 5'd16, 32'hBEEF0000, 1'b1};
        vecs[7] = '{32'h00000003, 5'd2,  32'h0000000C, 1'b0};

        reset             = 1'b1;
        bus.ctrl_start    = 1'b0;
        bus.data_operandA = '0;
        bus.ctrl_shiftamt = '0;
        tick();
        tick();
        check("reset result", 64'(bus.data_result), 64'd0);
        check("reset rdy", 64'(bus.data_resultRDY), 64'd0);
        check("reset busy", 64'(bus.data_busy), 64'd0);
`ifdef SLL_OVERFLOW_EN
        check("reset overflow", 64'(bus.data_overflow), 64'd0);
`endif
        reset = 1'b0;
        tick();
        check("idle without start", 64'(bus.data_busy), 64'd0);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].amt, vecs[i].exp_res, vecs[i].exp_ovf);
        end

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            ra   = $urandom;
            ramt = SW'($urandom_range(0, SW == 5 ? 31 : 0));
            if (i % 3 == 0) ra = {W{ra[W-1]}} ^ (ra >> $urandom_range(1, 31));
            run_op($sformatf("rand%0d", i), ra, ramt, model_res(ra, ramt), model_ovf(ra, ramt));
        end

        // Second start during SHIFT is ignored.
        bus.ctrl_start    = 1'b1;
        bus.data_operandA = 32'h0000000F;
        bus.ctrl_shiftamt = 5'd8;
        tick();
        bus.ctrl_start = 1'b0;
        tick();
        bus.ctrl_start    = 1'b1;
        bus.data_operandA = 32'hAAAAAAAA;
        bus.ctrl_shiftamt = 5'd5;
        tick();
        bus.ctrl_start = 1'b0;
        pulses = 0;
        first  = 0;
        for (int c = 3; c <= 16; c++) begin
            if (bus.data_resultRDY) begin
                pulses++;
                if (first == 0) first = c;
            end
            tick();
        end
        check("drop: first rdy cycle", 64'(first), 64'd6);
        check("drop: rdy pulses", 64'(pulses), 64'd1);
        check("drop: result", 64'(bus.data_result), 64'h00000F00);
        last_res = 32'h00000F00;

        // Reset in the middle of a shift.
        run_op("pre-reset", 32'h5, 5'd1, 32'hA, 1'b0);
        bus.ctrl_start    = 1'b1;
        bus.data_operandA = 32'h12345678;
        bus.ctrl_shiftamt = 5'd4;
        tick();
        bus.ctrl_start = 1'b0;
        tick();
        tick();
        check("mid-shift busy", 64'(bus.data_busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset mid-shift busy", 64'(bus.data_busy), 64'd0);
        check("reset mid-shift rdy", 64'(bus.data_resultRDY), 64'd0);
        check("reset mid-shift result", 64'(bus.data_result), 64'd0);
`ifdef SLL_OVERFLOW_EN
        check("reset mid-shift overflow", 64'(bus.data_overflow), 64'd0);
`endif
        last_res = '0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.data_resultRDY) pulses++;
            tick();
        end
        check("no rdy after reset", 64'(pulses), 64'd0);
        run_op("post-reset", 32'h3, 5'd2, 32'hC, 1'b0);

        // Start held high: the start seen in DONE begins the next operation.
        bus.ctrl_start    = 1'b1;
        bus.data_operandA = 32'h1;
        bus.ctrl_shiftamt = 5'd1;
        tick();
        bus.ctrl_shiftamt = 5'd3;
        pulses = 0;
        at[0] = 0;
        at[1] = 0;
        rs[0] = '0;
        rs[1] = '0;
        for (int c = 1; c <= 20; c++) begin
            if (bus.data_resultRDY) begin
                if (pulses < 2) begin
                    at[pulses] = c;
                    rs[pulses] = bus.data_result;
                end
                pulses++;
            end
            if (c == 12) bus.ctrl_start = 1'b0;
            tick();
        end
        check("b2b: rdy pulses", 64'(pulses), 64'd2);
        check("b2b: first rdy cycle", 64'(at[0]), 64'd6);
        check("b2b: second rdy cycle", 64'(at[1]), 64'd12);
        check("b2b: first result", 64'(rs[0]), 64'h2);
        check("b2b: second result", 64'(rs[1]), 64'h8);
        check("b2b: idle at end", 64'(bus.data_busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
